iq_averager: RTL and testbench

//   Windowed mean of a signed I or Q amplitude stream in the MSF receive chain.

---
 rtl/iq_averager_if.sv | 24 ++
 rtl/iq_averager.sv | 86 ++++++++
 tb/tb_iq_averager.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/iq_averager_if.sv
// iq_averager_if: sample stream in, windowed mean and live window state out
interface iq_averager_if #(
  parameter int AMP_W = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 13
);
  logic signed [AMP_W-1:0] amplitude;
  logic                    load_val;
  logic                    msf_carrier_pulse;
  logic                    one_sec_marker;
  logic [CNT_W-1:0]        number_msf_periods;
  logic signed [AMP_W-1:0] average;
  logic                    valid;
  logic [CNT_W-1:0]        counter;
  logic signed [ACC_W-1:0] accumulator;
  modport master (
    output amplitude, load_val, msf_carrier_pulse, one_sec_marker, number_msf_periods,
    input  average, valid, counter, accumulator
  );
  modport slave (
    input  amplitude, load_val, msf_carrier_pulse, one_sec_marker, number_msf_periods,
    output average, valid, counter, accumulator
  );
endinterface

// File: rtl/iq_averager.sv
// iq_averager: windowed mean of a signed amplitude stream over N MSF carrier periods
module iq_averager #(
  parameter int AMP_W = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 13,
  parameter int SMP_W = 9
) (
  input logic         clk,
  input logic         rst,
  iq_averager_if.slave bus
);
  localparam logic [SMP_W-1:0] SMP_MAX = SMP_W'(2 ** (SMP_W - 1));
  localparam logic [ACC_W-1:0] AMP_LIM = ACC_W'(2 ** (AMP_W - 1));
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t           state;
  logic             marker_q, mark_rise, take, close, fits, neg;
  logic [SMP_W-1:0] smp_cnt, smp_nxt, den;
  logic [SMP_W:0]   rem, rem_sh;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] sat_sum, acc_nxt, mag, quo;
  logic [CNT_W-1:0] n_eff;
  logic [4:0]       iter;
  logic [AMP_W-1:0] avg_nxt;
  always_comb begin
    mark_rise = bus.one_sec_marker & ~marker_q;
    take      = bus.load_val & (smp_cnt != SMP_MAX);
    sum       = {bus.accumulator[ACC_W-1], bus.accumulator}
              + {{(ACC_W + 1 - AMP_W){bus.amplitude[AMP_W-1]}}, bus.amplitude};
    sat_sum   = (sum[ACC_W] == sum[ACC_W-1]) ? sum[ACC_W-1:0] : {sum[ACC_W], {(ACC_W - 1){~sum[ACC_W]}}};
    acc_nxt   = take ? sat_sum : bus.accumulator;
    smp_nxt   = smp_cnt + SMP_W'(take);
    n_eff     = (bus.number_msf_periods == '0) ? CNT_W'(1) : bus.number_msf_periods;
    close     = bus.msf_carrier_pulse & (({1'b0, bus.counter} + (CNT_W + 1)'(1)) >= {1'b0, n_eff});
    mag       = acc_nxt[ACC_W-1] ? -acc_nxt : acc_nxt;
    rem_sh    = {rem[SMP_W-1:0], quo[ACC_W-1]};
    fits      = rem_sh >= {1'b0, den};
    avg_nxt   = neg ? ((quo > AMP_LIM) ? {1'b1, {(AMP_W - 1){1'b0}}} : -quo[AMP_W-1:0])
                    : ((quo >= AMP_LIM) ? {1'b0, {(AMP_W - 1){1'b1}}} : quo[AMP_W-1:0]);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      marker_q        <= 1'b0;
      smp_cnt         <= '0;
      bus.accumulator <= '0;
      bus.counter     <= '0;
      bus.average     <= '0;
      bus.valid       <= 1'b0;
      state           <= IDLE;
      quo             <= '0;
      rem             <= '0;
      den             <= '0;
      neg             <= 1'b0;
      iter            <= '0;
    end else begin
      marker_q  <= bus.one_sec_marker;
      bus.valid <= 1'b0;
      if (mark_rise || close) begin
        bus.accumulator <= '0;
        bus.counter     <= '0;
        smp_cnt         <= '0;
      end else begin
        bus.accumulator <= acc_nxt;
        smp_cnt         <= smp_nxt;
        if (bus.msf_carrier_pulse) bus.counter <= bus.counter + CNT_W'(1);
      end
      // a fresh close always wins over an in-flight or finishing divide
      if (!mark_rise && close) begin
        quo   <= mag;
        den   <= smp_nxt;
        rem   <= '0;
        neg   <= acc_nxt[ACC_W-1];
        iter  <= '0;
        state <= (smp_nxt == '0) ? DONE : DIV;
      end else if (state == DIV) begin
        quo   <= {quo[ACC_W-2:0], fits};
        rem   <= fits ? rem_sh - {1'b0, den} : rem_sh;
        iter  <= iter + 5'd1;
        state <= (iter == 5'(ACC_W - 1)) ? DONE : DIV;
      end else if (state == DONE) begin
        bus.average <= avg_nxt;
        bus.valid   <= 1'b1;
        state       <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_iq_averager.sv
// tb_iq_averager: directed scenario tests for iq_averager
module tb_iq_averager;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int n_valid = 0;
  logic signed [15:0] last_avg = '0;
  always #5 clk = ~clk;
  iq_averager_if bus ();
  iq_averager dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic cyc(input logic l, input logic m);
    bus.load_val = l;
    bus.msf_carrier_pulse = m;
    @(posedge clk);
    #1;
    bus.load_val = 1'b0;
    bus.msf_carrier_pulse = 1'b0;
    if (bus.valid) begin
      n_valid++;
      last_avg = bus.average;
    end
  endtask
  task automatic do_reset();
    rst = 1'b0;
    bus.load_val = 1'b0;
    bus.msf_carrier_pulse = 1'b0;
    bus.one_sec_marker = 1'b0;
    bus.amplitude = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    n_valid = 0;
  endtask
  task automatic test_reset();
    bus.load_val = 1'b0;
    bus.msf_carrier_pulse = 1'b0;
    bus.one_sec_marker = 1'b0;
    bus.amplitude = 16'sd1080;
    bus.number_msf_periods = 13'd16;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_chk++; if (bus.average !== 16'sd0) begin n_fail++; $display("FAIL reset_average got %0d want 0", bus.average); end
    n_chk++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    n_chk++; if (bus.counter !== 13'd0) begin n_fail++; $display("FAIL reset_counter got %0d want 0", bus.counter); end
    n_chk++; if (bus.accumulator !== 24'sd0) begin n_fail++; $display("FAIL reset_acc got %0d want 0", bus.accumulator); end
    rst = 1'b1;
  endtask
  task automatic test_steady();
    do_reset();
    bus.amplitude = 16'sd1080;
    bus.number_msf_periods = 13'd16;
    for (int k = 0; k < 7950; k++) begin
      cyc(k % 501 == 0, k % 165 == 164);
      if (bus.valid) begin
        n_chk++; if (bus.average !== 16'sd1080) begin n_fail++; $display("FAIL steady_avg k=%0d got %0d want 1080", k, bus.average); end
      end
    end
    n_chk++; if (n_valid !== 3) begin n_fail++; $display("FAIL steady_count got %0d want 3", n_valid); end
  endtask
  task automatic test_step();
    logic signed [15:0] exp;
    do_reset();
    bus.number_msf_periods = 13'd16;
    for (int k = 0; k < 5305; k++) begin
      bus.amplitude = (k < 1300) ? 16'sd1080 : 16'sd108;
      cyc(k % 501 == 0, k % 165 == 164);
      if (bus.valid) begin
        exp = (n_valid == 1) ? 16'sd594 : 16'sd108;
        n_chk++; if (bus.average !== exp) begin n_fail++; $display("FAIL step_avg k=%0d got %0d want %0d", k, bus.average, exp); end
      end
    end
    n_chk++; if (n_valid !== 2) begin n_fail++; $display("FAIL step_count got %0d want 2", n_valid); end
  endtask
  task automatic test_saturation();
    int lat;
    do_reset();
    bus.number_msf_periods = 13'd1;
    for (int i = 0; i < 256; i++) begin
      bus.amplitude = (i % 2 == 0) ? -16'sd32768 : 16'sd32767;
      cyc(1'b1, 1'b0);
    end
    n_chk++; if (bus.accumulator !== 24'hFFFF80) begin n_fail++; $display("FAIL alt_acc got %0d want -128", bus.accumulator); end
    bus.amplitude = 16'sd32767;
    cyc(1'b1, 1'b0);
    n_chk++; if (bus.accumulator !== 24'hFFFF80) begin n_fail++; $display("FAIL smp_max_ignore got %0d want -128", bus.accumulator); end
    cyc(1'b0, 1'b1);
    n_chk++; if (bus.accumulator !== 24'sd0) begin n_fail++; $display("FAIL close_clear got %0d want 0", bus.accumulator); end
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b0, 1'b0);
      if (bus.valid && lat == 0) lat = i;
    end
    n_chk++; if (lat !== 25) begin n_fail++; $display("FAIL latency got %0d want 25", lat); end
    n_chk++; if (last_avg !== 16'sd0) begin n_fail++; $display("FAIL alt_avg got %0d want 0", last_avg); end
    bus.amplitude = 16'sd32767;
    for (int i = 0; i < 299; i++) cyc(1'b1, 1'b0);
    n_chk++; if (bus.accumulator !== 24'h7FFF00) begin n_fail++; $display("FAIL pos_acc got %0d want 8388352", bus.accumulator); end
    cyc(1'b1, 1'b1);
    repeat (26) cyc(1'b0, 1'b0);
    n_chk++; if (last_avg !== 16'sd32767) begin n_fail++; $display("FAIL pos_avg got %0d want 32767", last_avg); end
    bus.amplitude = -16'sd32768;
    for (int i = 0; i < 256; i++) cyc(1'b1, 1'b0);
    n_chk++; if (bus.accumulator !== 24'h800000) begin n_fail++; $display("FAIL neg_acc got %0d want -8388608", bus.accumulator); end
    cyc(1'b0, 1'b1);
    repeat (26) cyc(1'b0, 1'b0);
    n_chk++; if (last_avg !== -16'sd32768) begin n_fail++; $display("FAIL neg_avg got %0d want -32768", last_avg); end
  endtask
  task automatic test_marker();
    int first_k;
    do_reset();
    bus.amplitude = 16'sd1080;
    bus.number_msf_periods = 13'd16;
    first_k = -1;
    for (int k = 0; k < 3700; k++) begin
      bus.one_sec_marker = (k >= 1002 && k <= 1166);
      cyc(k % 501 == 0, k % 165 == 164);
      if (bus.valid && first_k < 0) first_k = k;
      if (k == 1001) begin
        n_chk++; if (bus.counter !== 13'd6 || bus.accumulator !== 24'sd2160) begin n_fail++; $display("FAIL pre_marker got cnt=%0d acc=%0d want 6/2160", bus.counter, bus.accumulator); end
      end
      if (k == 1002) begin
        n_chk++; if (bus.counter !== 13'd0 || bus.accumulator !== 24'sd0) begin n_fail++; $display("FAIL marker_abort got cnt=%0d acc=%0d want 0/0", bus.counter, bus.accumulator); end
      end
      if (k == 1166) begin
        n_chk++; if (bus.counter !== 13'd1 || bus.accumulator !== 24'sd0) begin n_fail++; $display("FAIL marker_hold got cnt=%0d acc=%0d want 1/0", bus.counter, bus.accumulator); end
      end
      if (k == 1503) begin
        n_chk++; if (bus.accumulator !== 24'sd1080) begin n_fail++; $display("FAIL post_marker_acc got %0d want 1080", bus.accumulator); end
      end
    end
    n_chk++; if (first_k !== 3654) begin n_fail++; $display("FAIL marker_first_valid got %0d want 3654", first_k); end
    n_chk++; if (last_avg !== 16'sd1080) begin n_fail++; $display("FAIL marker_avg got %0d want 1080", last_avg); end
  endtask
  task automatic test_short_windows();
    do_reset();
    bus.number_msf_periods = 13'd0;
    bus.amplitude = 16'sd500;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    n_chk++; if (bus.counter !== 13'd0 || bus.accumulator !== 24'sd0) begin n_fail++; $display("FAIL n0_close got cnt=%0d acc=%0d want 0/0", bus.counter, bus.accumulator); end
    repeat (25) cyc(1'b0, 1'b0);
    n_chk++; if (bus.valid !== 1'b1 || bus.average !== 16'sd500) begin n_fail++; $display("FAIL n0_avg got v=%b avg=%0d want 1/500", bus.valid, bus.average); end
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    n_chk++; if (bus.valid !== 1'b1 || bus.average !== 16'sd0) begin n_fail++; $display("FAIL empty_window got v=%b avg=%0d want 1/0", bus.valid, bus.average); end
    bus.number_msf_periods = 13'd1;
    bus.amplitude = 16'sd100;
    cyc(1'b1, 1'b0);
    bus.amplitude = 16'sd200;
    cyc(1'b1, 1'b1);
    repeat (26) cyc(1'b0, 1'b0);
    n_chk++; if (last_avg !== 16'sd150) begin n_fail++; $display("FAIL n1_avg got %0d want 150", last_avg); end
    n_valid = 0;
    bus.amplitude = 16'sd300;
    cyc(1'b1, 1'b1);
    repeat (5) cyc(1'b0, 1'b0);
    bus.amplitude = 16'sd900;
    cyc(1'b1, 1'b1);
    repeat (30) cyc(1'b0, 1'b0);
    n_chk++; if (n_valid !== 1 || last_avg !== 16'sd900) begin n_fail++; $display("FAIL restart got n=%0d avg=%0d want 1/900", n_valid, last_avg); end
    bus.number_msf_periods = 13'd16;
    repeat (5) cyc(1'b0, 1'b1);
    n_chk++; if (bus.counter !== 13'd5) begin n_fail++; $display("FAIL n16_count got %0d want 5", bus.counter); end
    bus.number_msf_periods = 13'd3;
    cyc(1'b0, 1'b1);
    n_chk++; if (bus.counter !== 13'd0) begin n_fail++; $display("FAIL lowered_n got %0d want 0", bus.counter); end
    cyc(1'b0, 1'b0);
    n_chk++; if (bus.valid !== 1'b1 || bus.average !== 16'sd0) begin n_fail++; $display("FAIL lowered_n_avg got v=%b avg=%0d want 1/0", bus.valid, bus.average); end
  endtask
  task automatic test_reset_mid_divide();
    do_reset();
    bus.number_msf_periods = 13'd1;
    bus.amplitude = 16'sd700;
    cyc(1'b1, 1'b1);
    repeat (26) cyc(1'b0, 1'b0);
    n_chk++; if (bus.average !== 16'sd700) begin n_fail++; $display("FAIL pre_rst_avg got %0d want 700", bus.average); end
    cyc(1'b1, 1'b1);
    repeat (10) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    n_chk++; if (bus.average !== 16'sd0 || bus.accumulator !== 24'sd0 || bus.valid !== 1'b0) begin n_fail++; $display("FAIL async_rst got avg=%0d acc=%0d v=%b want 0/0/0", bus.average, bus.accumulator, bus.valid); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    n_valid = 0;
    repeat (40) cyc(1'b0, 1'b0);
    n_chk++; if (n_valid !== 0) begin n_fail++; $display("FAIL rst_no_valid got %0d want 0", n_valid); end
  endtask
  initial begin
    test_reset();
    test_steady();
    test_step();
    test_saturation();
    test_marker();
    test_short_windows();
    test_reset_mid_divide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
